// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered entries with CDB wakeup, oldest-ready select and compaction.
// Optional ISSUEQ_WAKEUP_BYPASS_EN lets a same-cycle CDB match make an entry selectable at once.
module int_issue_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            dispatch_valid_i,
   input  logic [5:0]      dispatch_opcode_i,
   input  logic [5:0]      dispatch_rstag_i,
   input  logic [5:0]      dispatch_rttag_i,
   input  logic            dispatch_rsvalid_i,
   input  logic            dispatch_rtvalid_i,
   input  logic [31:0]     dispatch_rsdata_i,
   input  logic [31:0]     dispatch_rtdata_i,
   input  logic [5:0]      dispatch_rdtag_i,
   input  logic            flush_i,
   input  logic            cdb_valid_i,
   input  logic [5:0]      cdb_tag_i,
   input  logic [31:0]     cdb_data_i,
   input  logic            issueint_equeueint_done_i,
   output logic            issueint_ready_o,
   output logic [5:0]      issueint_opcode_o,
   output logic [31:0]     issueint_rsdata_o,
   output logic [31:0]     issueint_rtdata_o,
   output logic [5:0]      issueint_rdtag_o,
   output logic            issueq_full_o,
   output logic [CNTW-1:0] issueq_count_o
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic        valid;
      logic [5:0]  opcode;
      logic [5:0]  rdtag;
      logic [5:0]  rs_tag;
      logic        rs_dval;
      logic [31:0] rs_data;
      logic [5:0]  rt_tag;
      logic        rt_dval;
      logic [31:0] rt_data;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   entry_t            ent_w [DEPTH];
   entry_t            new_ent;
   logic [DEPTH-1:0]  rdy;
   logic              sel_found;
   logic [IdxW-1:0]   sel_idx;
   logic              issue_ready;
   logic              remove;
   logic              accept;
   logic [CNTW-1:0]   wr_idx;
   logic [CNTW-1:0]   count_q, count_d;
   logic              full_q, full_d;

   // Entries as they look after this cycle's CDB snoop.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         ent_w[i] = ent_q[i];
         if (cdb_valid_i && ent_q[i].valid && !ent_q[i].rs_dval &&
             (ent_q[i].rs_tag == cdb_tag_i)) begin
            ent_w[i].rs_dval = 1'b1;
            ent_w[i].rs_data = cdb_data_i;
         end
         if (cdb_valid_i && ent_q[i].valid && !ent_q[i].rt_dval &&
             (ent_q[i].rt_tag == cdb_tag_i)) begin
            ent_w[i].rt_dval = 1'b1;
            ent_w[i].rt_data = cdb_data_i;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
         rdy[i] = ent_w[i].valid & ent_w[i].rs_dval & ent_w[i].rt_dval;
`else
         rdy[i] = ent_q[i].valid & ent_q[i].rs_dval & ent_q[i].rt_dval;
`endif
      end
   end

   // Lowest index wins: entry 0 is the oldest.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (rdy[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = IdxW'(i);
         end
      end
   end

   assign issue_ready = sel_found & ~flush_i;

   always_comb begin
      issueint_ready_o  = issue_ready;
      issueint_opcode_o = '0;
      issueint_rsdata_o = '0;
      issueint_rtdata_o = '0;
      issueint_rdtag_o  = '0;
      if (issue_ready) begin
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
         issueint_opcode_o = ent_w[sel_idx].opcode;
         issueint_rsdata_o = ent_w[sel_idx].rs_data;
         issueint_rtdata_o = ent_w[sel_idx].rt_data;
         issueint_rdtag_o  = ent_w[sel_idx].rdtag;
`else
         issueint_opcode_o = ent_q[sel_idx].opcode;
         issueint_rsdata_o = ent_q[sel_idx].rs_data;
         issueint_rtdata_o = ent_q[sel_idx].rt_data;
         issueint_rdtag_o  = ent_q[sel_idx].rdtag;
`endif
      end
   end

   assign remove = issue_ready & issueint_equeueint_done_i;
   assign accept = dispatch_valid_i & ~full_q & ~flush_i;
   assign wr_idx = count_q - CNTW'(remove);

   // Incoming op, including a capture of a same-cycle CDB broadcast.
   always_comb begin
      new_ent        = '0;
      new_ent.valid  = 1'b1;
      new_ent.opcode = dispatch_opcode_i;
      new_ent.rdtag  = dispatch_rdtag_i;
      new_ent.rs_tag = dispatch_rstag_i;
      new_ent.rt_tag = dispatch_rttag_i;
      if (dispatch_rsvalid_i) begin
         new_ent.rs_dval = 1'b1;
         new_ent.rs_data = dispatch_rsdata_i;
      end else if (cdb_valid_i && (dispatch_rstag_i == cdb_tag_i)) begin
         new_ent.rs_dval = 1'b1;
         new_ent.rs_data = cdb_data_i;
      end
      if (dispatch_rtvalid_i) begin
         new_ent.rt_dval = 1'b1;
         new_ent.rt_data = dispatch_rtdata_i;
      end else if (cdb_valid_i && (dispatch_rttag_i == cdb_tag_i)) begin
         new_ent.rt_dval = 1'b1;
         new_ent.rt_data = cdb_data_i;
      end
   end

   // Compaction: slots at or above the removed one pull from their upper neighbour.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         int src;
         src = i;
         if (remove && (i >= int'(sel_idx))) begin
            src = i + 1;
         end
         if (src < int'(DEPTH)) begin
            ent_d[i] = ent_w[IdxW'(src)];
         end else begin
            ent_d[i] = '0;
         end
         if (accept && (CNTW'(i) == wr_idx)) begin
            ent_d[i] = new_ent;
         end
         if (flush_i) begin
            ent_d[i] = '0;
         end
      end
   end

   always_comb begin
      count_d = count_q - CNTW'(remove) + CNTW'(accept);
      if (flush_i) begin
         count_d = '0;
      end
      full_d = (count_d == CNTW'(DEPTH));
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_q[i] <= '0;
         end
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_q[i] <= ent_d[i];
         end
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign issueq_full_o  = full_q;
   assign issueq_count_o = count_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios plus randomized traffic against a queue model.
module tb_int_issue_queue;

   localparam int DEPTH = 8;
   localparam int CNTW  = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic            dispatch_valid;
   logic [5:0]      dispatch_opcode;
   logic [5:0]      dispatch_rstag, dispatch_rttag;
   logic            dispatch_rsvalid, dispatch_rtvalid;
   logic [31:0]     dispatch_rsdata, dispatch_rtdata;
   logic [5:0]      dispatch_rdtag;
   logic            flush;
   logic            cdb_valid;
   logic [5:0]      cdb_tag;
   logic [31:0]     cdb_data;
   logic            done;
   logic            issueint_ready;
   logic [5:0]      issueint_opcode;
   logic [31:0]     issueint_rsdata, issueint_rtdata;
   logic [5:0]      issueint_rdtag;
   logic            issueq_full;
   logic [CNTW-1:0] issueq_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  rd;
      logic [5:0]  rst;
      logic [5:0]  rtt;
      bit          rsv;
      bit          rtv;
      logic [31:0] rsd;
      logic [31:0] rtd;
   } m_ent_t;

   int_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk_i                     (clk),
      .reset_i                   (reset),
      .dispatch_valid_i          (dispatch_valid),
      .dispatch_opcode_i         (dispatch_opcode),
      .dispatch_rstag_i          (dispatch_rstag),
      .dispatch_rttag_i          (dispatch_rttag),
      .dispatch_rsvalid_i        (dispatch_rsvalid),
      .dispatch_rtvalid_i        (dispatch_rtvalid),
      .dispatch_rsdata_i         (dispatch_rsdata),
      .dispatch_rtdata_i         (dispatch_rtdata),
      .dispatch_rdtag_i          (dispatch_rdtag),
      .flush_i                   (flush),
      .cdb_valid_i               (cdb_valid),
      .cdb_tag_i                 (cdb_tag),
      .cdb_data_i                (cdb_data),
      .issueint_equeueint_done_i (done),
      .issueint_ready_o          (issueint_ready),
      .issueint_opcode_o         (issueint_opcode),
      .issueint_rsdata_o         (issueint_rsdata),
      .issueint_rtdata_o         (issueint_rtdata),
      .issueint_rdtag_o          (issueint_rdtag),
      .issueq_full_o             (issueq_full),
      .issueq_count_o            (issueq_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_idle();
      dispatch_valid   = 1'b0;
      dispatch_opcode  = '0;
      dispatch_rstag   = '0;
      dispatch_rttag   = '0;
      dispatch_rsvalid = 1'b0;
      dispatch_rtvalid = 1'b0;
      dispatch_rsdata  = '0;
      dispatch_rtdata  = '0;
      dispatch_rdtag   = '0;
      flush            = 1'b0;
      cdb_valid        = 1'b0;
      cdb_tag          = '0;
      cdb_data         = '0;
      done             = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drive_disp(input logic [5:0] op, input logic [5:0] rst, input logic rsv,
                             input logic [31:0] rsd, input logic [5:0] rtt, input logic rtv,
                             input logic [31:0] rtd, input logic [5:0] rd);
      dispatch_valid   = 1'b1;
      dispatch_opcode  = op;
      dispatch_rstag   = rst;
      dispatch_rsvalid = rsv;
      dispatch_rsdata  = rsd;
      dispatch_rttag   = rtt;
      dispatch_rtvalid = rtv;
      dispatch_rtdata  = rtd;
      dispatch_rdtag   = rd;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b1;
      #3;
      checks++; if (issueint_ready !== 1'b0) begin errors++;
         $display("FAIL reset_ready: got %0h want 0", issueint_ready); end
      checks++; if (issueq_count !== '0) begin errors++;
         $display("FAIL reset_count: got %0d want 0", issueq_count); end
      checks++; if (issueq_full !== 1'b0) begin errors++;
         $display("FAIL reset_full: got %0h want 0", issueq_full); end
      checks++; if ({issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag} !== '0)
         begin errors++; $display("FAIL reset_outputs: got nonzero issue fields want 0"); end
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_dispatch();
      do_reset();
      drive_disp(6'h20, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 6'd3);
      #1;
      checks++; if (issueint_ready !== 1'b0) begin errors++;
         $display("FAIL disp_same_cycle_ready: got %0h want 0", issueint_ready); end
      tick();
      set_idle();
      #1;
      checks++; if (issueint_ready !== 1'b1) begin errors++;
         $display("FAIL disp_ready: got %0h want 1", issueint_ready); end
      checks++; if ({issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag} !==
                    {6'h20, 32'd5, 32'd7, 6'd3}) begin errors++;
         $display("FAIL disp_fields: got op=%0h rs=%0h rt=%0h rd=%0h want 20/5/7/3",
                  issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag); end
      checks++; if (issueq_count !== CNTW'(1)) begin errors++;
         $display("FAIL disp_count: got %0d want 1", issueq_count); end
      done = 1'b1;
      tick();
      done = 1'b0;
      #1;
      checks++; if (issueq_count !== '0 || issueint_ready !== 1'b0) begin errors++;
         $display("FAIL disp_done_empty: got count=%0d ready=%0h want 0/0",
                  issueq_count, issueint_ready); end
   endtask

   task automatic test_wakeup();
      do_reset();
      drive_disp(6'h05, 6'd9, 1'b0, 32'd0, 6'd1, 1'b1, 32'h22, 6'd4);
      tick();
      set_idle();
      tick();
      checks++; if (issueint_ready !== 1'b0) begin errors++;
         $display("FAIL wake_pending: got %0h want 0", issueint_ready); end
      cdb_valid = 1'b1;
      cdb_tag   = 6'd9;
      cdb_data  = 32'hDEAD;
      #1;
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
      checks++; if (issueint_ready !== 1'b1 || issueint_rsdata !== 32'hDEAD) begin errors++;
         $display("FAIL wake_bypass: got ready=%0h rs=%0h want 1/dead",
                  issueint_ready, issueint_rsdata); end
`else
      checks++; if (issueint_ready !== 1'b0) begin errors++;
         $display("FAIL wake_cdb_cycle: got %0h want 0", issueint_ready); end
`endif
      tick();
      set_idle();
      #1;
      checks++; if (issueint_ready !== 1'b1 || issueint_rsdata !== 32'hDEAD ||
                    issueint_rtdata !== 32'h22 || issueint_rdtag !== 6'd4) begin errors++;
         $display("FAIL wake_ready: got ready=%0h rs=%0h rt=%0h rd=%0h want 1/dead/22/4",
                  issueint_ready, issueint_rsdata, issueint_rtdata, issueint_rdtag); end
   endtask

   task automatic test_age_order();
      do_reset();
      drive_disp(6'h10, 6'd10, 1'b0, 32'd0, 6'd30, 1'b1, 32'hA1, 6'd20);
      tick();
      drive_disp(6'h11, 6'd11, 1'b0, 32'd0, 6'd31, 1'b1, 32'hB2, 6'd21);
      tick();
      drive_disp(6'h12, 6'd12, 1'b0, 32'd0, 6'd32, 1'b1, 32'hC3, 6'd22);
      tick();
      set_idle();
      cdb_valid = 1'b1; cdb_tag = 6'd11; cdb_data = 32'hB1;
      tick();
      set_idle();
      #1;
      checks++; if (issueint_ready !== 1'b1 || issueint_rdtag !== 6'd21) begin errors++;
         $display("FAIL age_young_first: got ready=%0h rd=%0d want 1/21",
                  issueint_ready, issueint_rdtag); end
      cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'hA0;
      tick();
      set_idle();
      #1;
      checks++; if (issueint_rdtag !== 6'd20 || issueint_rsdata !== 32'hA0) begin errors++;
         $display("FAIL age_oldest_wins: got rd=%0d rs=%0h want 20/a0",
                  issueint_rdtag, issueint_rsdata); end
      done = 1'b1;
      tick();
      done = 1'b0;
      #1;
      checks++; if ({issueint_ready, issueint_opcode, issueint_rsdata, issueint_rtdata,
                     issueint_rdtag} !== {1'b1, 6'h11, 32'hB1, 32'hB2, 6'd21}) begin errors++;
         $display("FAIL age_shifted: got ready=%0h op=%0h rs=%0h rt=%0h rd=%0d want 1/11/b1/b2/21",
                  issueint_ready, issueint_opcode, issueint_rsdata, issueint_rtdata,
                  issueint_rdtag); end
      checks++; if (issueq_count !== CNTW'(2)) begin errors++;
         $display("FAIL age_count: got %0d want 2", issueq_count); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive_disp(6'(i + 1), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i), 6'(i));
         tick();
      end
      set_idle();
      #1;
      checks++; if (issueq_full !== 1'b1 || issueq_count !== CNTW'(DEPTH)) begin errors++;
         $display("FAIL full_flag: got full=%0h count=%0d want 1/%0d",
                  issueq_full, issueq_count, DEPTH); end
      drive_disp(6'h3F, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'h3F);
      done = 1'b1;
      tick();
      set_idle();
      #1;
      checks++; if (issueq_full !== 1'b0 || issueq_count !== CNTW'(DEPTH - 1)) begin errors++;
         $display("FAIL full_drop_count: got full=%0h count=%0d want 0/%0d",
                  issueq_full, issueq_count, DEPTH - 1); end
      for (int i = 1; i < DEPTH; i++) begin
         checks++; if (issueint_ready !== 1'b1 || issueint_rdtag !== 6'(i)) begin errors++;
            $display("FAIL full_drain_order: got ready=%0h rd=%0d want 1/%0d",
                     issueint_ready, issueint_rdtag, i); end
         done = 1'b1;
         tick();
         done = 1'b0;
         #1;
      end
      checks++; if (issueint_ready !== 1'b0 || issueq_count !== '0) begin errors++;
         $display("FAIL full_drained: got ready=%0h count=%0d want 0/0",
                  issueint_ready, issueq_count); end
   endtask

   task automatic test_capture();
      do_reset();
      drive_disp(6'h07, 6'd2, 1'b1, 32'h1, 6'd4, 1'b0, 32'd0, 6'd8);
      cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h11;
      tick();
      set_idle();
      #1;
      checks++; if (issueint_ready !== 1'b1 || issueint_rtdata !== 32'h11 ||
                    issueint_rsdata !== 32'h1) begin errors++;
         $display("FAIL capture: got ready=%0h rt=%0h rs=%0h want 1/11/1",
                  issueint_ready, issueint_rtdata, issueint_rsdata); end
   endtask

   task automatic test_flush_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_disp(6'h01, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h6, 6'(i));
         tick();
      end
      set_idle();
      flush = 1'b1; done = 1'b1;
      drive_disp(6'h02, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h6, 6'd9);
      #1;
      checks++; if (issueint_ready !== 1'b0 || issueint_rdtag !== '0) begin errors++;
         $display("FAIL flush_ready: got ready=%0h rd=%0d want 0/0",
                  issueint_ready, issueint_rdtag); end
      tick();
      set_idle();
      #1;
      checks++; if (issueq_count !== '0 || issueint_ready !== 1'b0) begin errors++;
         $display("FAIL flush_count: got count=%0d ready=%0h want 0/0",
                  issueq_count, issueint_ready); end
      drive_disp(6'h03, 6'd0, 1'b1, 32'h77, 6'd0, 1'b1, 32'h88, 6'd5);
      tick();
      tick();
      set_idle();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({issueint_ready, issueint_opcode, issueint_rsdata, issueint_rtdata,
                     issueint_rdtag, issueq_full} !== '0 || issueq_count !== '0) begin errors++;
         $display("FAIL async_reset: got ready=%0h count=%0d rs=%0h want all 0",
                  issueint_ready, issueq_count, issueint_rsdata); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_random();
      m_ent_t mq[$];
      m_ent_t wq[$];
      m_ent_t ne;
      int     sel;
      bit     found;
      bit     e_rdy;
      logic [5:0]  e_op, e_rd;
      logic [31:0] e_rs, e_rt;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         dispatch_valid   = ($urandom_range(0, 9) < 6);
         dispatch_opcode  = 6'($urandom);
         dispatch_rstag   = 6'($urandom_range(0, 7));
         dispatch_rttag   = 6'($urandom_range(0, 7));
         dispatch_rsvalid = 1'($urandom_range(0, 1));
         dispatch_rtvalid = 1'($urandom_range(0, 1));
         dispatch_rsdata  = $urandom;
         dispatch_rtdata  = $urandom;
         dispatch_rdtag   = 6'($urandom);
         flush            = ($urandom_range(0, 49) == 0);
         cdb_valid        = 1'($urandom_range(0, 1));
         cdb_tag          = 6'($urandom_range(0, 7));
         cdb_data         = $urandom;
         done             = 1'($urandom_range(0, 1));
         #1;
         wq = mq;
         foreach (wq[i]) begin
            if (cdb_valid && !wq[i].rsv && wq[i].rst == cdb_tag) begin
               wq[i].rsv = 1'b1; wq[i].rsd = cdb_data;
            end
            if (cdb_valid && !wq[i].rtv && wq[i].rtt == cdb_tag) begin
               wq[i].rtv = 1'b1; wq[i].rtd = cdb_data;
            end
         end
         found = 1'b0;
         sel   = 0;
         for (int i = 0; i < mq.size(); i++) begin
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
            if (!found && wq[i].rsv && wq[i].rtv) begin found = 1'b1; sel = i; end
`else
            if (!found && mq[i].rsv && mq[i].rtv) begin found = 1'b1; sel = i; end
`endif
         end
         e_rdy = found && !flush;
         e_op = '0; e_rd = '0; e_rs = '0; e_rt = '0;
         if (e_rdy) begin
            e_op = wq[sel].op; e_rd = wq[sel].rd; e_rs = wq[sel].rsd; e_rt = wq[sel].rtd;
         end
         checks++; if (issueint_ready !== e_rdy) begin errors++;
            $display("FAIL rand_ready c=%0d: got %0h want %0h", c, issueint_ready, e_rdy); end
         checks++; if (issueint_opcode !== e_op || issueint_rdtag !== e_rd) begin errors++;
            $display("FAIL rand_op_rd c=%0d: got %0h/%0h want %0h/%0h", c, issueint_opcode,
                     issueint_rdtag, e_op, e_rd); end
         checks++; if (issueint_rsdata !== e_rs || issueint_rtdata !== e_rt) begin errors++;
            $display("FAIL rand_data c=%0d: got %0h/%0h want %0h/%0h", c, issueint_rsdata,
                     issueint_rtdata, e_rs, e_rt); end
         checks++; if (issueq_count !== CNTW'(mq.size())) begin errors++;
            $display("FAIL rand_count c=%0d: got %0d want %0d", c, issueq_count, mq.size()); end
         checks++; if (issueq_full !== (mq.size() == DEPTH)) begin errors++;
            $display("FAIL rand_full c=%0d: got %0h want %0h", c, issueq_full,
                     mq.size() == DEPTH); end
         if (flush) begin
            wq.delete();
         end else begin
            if (e_rdy && done) wq.delete(sel);
            if (dispatch_valid && mq.size() < DEPTH) begin
               ne.op  = dispatch_opcode;
               ne.rd  = dispatch_rdtag;
               ne.rst = dispatch_rstag;
               ne.rtt = dispatch_rttag;
               ne.rsv = dispatch_rsvalid || (cdb_valid && dispatch_rstag == cdb_tag);
               ne.rtv = dispatch_rtvalid || (cdb_valid && dispatch_rttag == cdb_tag);
               ne.rsd = dispatch_rsvalid ? dispatch_rsdata : cdb_data;
               ne.rtd = dispatch_rtvalid ? dispatch_rtdata : cdb_data;
               wq.push_back(ne);
            end
         end
         mq = wq;
         tick();
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_dispatch();
      test_wakeup();
      test_age_order();
      test_full();
      test_capture();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
